// File: rtl/wb_regfile.sv
// wb_regfile: Y86-64 write-back stage (W pipeline register) and architectural
// register file. Commits W_valE/W_valM, serves decode read ports, exports
// W-stage values for forwarding, and latches HALTED on a non-AOK status.
// Optional build macro: WB_WRITE_BYPASS_EN -- decode read ports return the
// committing W-stage value when the source matches a W destination.
module wb_regfile #(
    parameter int unsigned NREG = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic [63:0] M_valE,
    input  logic [63:0] m_valM,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic        W_stall,
    input  logic        W_bubble,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    output logic [63:0] d_rvalA,
    output logic [63:0] d_rvalB,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM,
    output logic [2:0]  Stat,
    output logic        halted
);
    localparam logic [3:0] RNONE     = 4'hF;
    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [2:0] STAT_AOK  = 3'd1;
    localparam logic [2:0] STAT_HLT  = 3'd2;
    localparam logic [2:0] STAT_ADR  = 3'd3;
    localparam logic [2:0] STAT_INS  = 3'd4;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_halted;
    logic [2:0]  r_stat;

    logic [2:0]  r_W_stat;
    logic [3:0]  r_W_icode;
    logic [63:0] r_W_valE;
    logic [63:0] r_W_valM;
    logic [3:0]  r_W_dstE;
    logic [3:0]  r_W_dstM;

    logic [63:0] r_regs [NREG];

    logic [2:0]  w_Wn_stat;
    logic [3:0]  w_Wn_icode;
    logic [63:0] w_Wn_valE;
    logic [63:0] w_Wn_valM;
    logic [3:0]  w_Wn_dstE;
    logic [3:0]  w_Wn_dstM;
    logic        w_commit;
    logic        w_wrE;
    logic        w_wrM;
    logic        w_halt_now;

    assign w_commit   = (r_state == S_RUN) && (r_W_stat == STAT_AOK);
    assign w_wrE      = w_commit && (r_W_dstE != RNONE) && (32'(r_W_dstE) < NREG);
    assign w_wrM      = w_commit && (r_W_dstM != RNONE) && (32'(r_W_dstM) < NREG);
    assign w_halt_now = (r_state == S_RUN) &&
                        ((r_W_stat == STAT_HLT) || (r_W_stat == STAT_ADR) ||
                         (r_W_stat == STAT_INS));

    // Next W register contents: stall holds, else bubble, else M-side inputs
    always_comb begin
        w_Wn_stat  = r_W_stat;
        w_Wn_icode = r_W_icode;
        w_Wn_valE  = r_W_valE;
        w_Wn_valM  = r_W_valM;
        w_Wn_dstE  = r_W_dstE;
        w_Wn_dstM  = r_W_dstM;
        if (!W_stall) begin
            if (W_bubble) begin
                w_Wn_stat  = STAT_AOK;
                w_Wn_icode = ICODE_NOP;
                w_Wn_valE  = '0;
                w_Wn_valM  = '0;
                w_Wn_dstE  = RNONE;
                w_Wn_dstM  = RNONE;
            end else begin
                w_Wn_stat  = M_stat;
                w_Wn_icode = M_icode;
                w_Wn_valE  = M_valE;
                w_Wn_valM  = m_valM;
                w_Wn_dstE  = M_dstE;
                w_Wn_dstM  = M_dstM;
            end
        end
    end

    // W pipeline register; frozen once halted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_W_stat  <= STAT_AOK;
            r_W_icode <= ICODE_NOP;
            r_W_valE  <= '0;
            r_W_valM  <= '0;
            r_W_dstE  <= RNONE;
            r_W_dstM  <= RNONE;
        end else if (r_state == S_RUN) begin
            r_W_stat  <= w_Wn_stat;
            r_W_icode <= w_Wn_icode;
            r_W_valE  <= w_Wn_valE;
            r_W_valM  <= w_Wn_valM;
            r_W_dstE  <= w_Wn_dstE;
            r_W_dstM  <= w_Wn_dstM;
        end
    end

    // Run/halt state machine; Stat tracks the next W status until the halting edge latches it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_RUN;
            r_stat   <= STAT_AOK;
            r_halted <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (w_halt_now) begin
                r_state  <= S_HALTED;
                r_stat   <= r_W_stat;
                r_halted <= 1'b1;
            end else begin
                r_stat   <= w_Wn_stat;
            end
        end
    end

    // Register file commit; the valM port is written last so it wins on a shared destination
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wrE) r_regs[r_W_dstE] <= r_W_valE;
            if (w_wrM) r_regs[r_W_dstM] <= r_W_valM;
        end
    end

    function automatic logic [63:0] f_read(input logic [3:0] src);
        logic [63:0] v;
        v = '0;
        if ((src != RNONE) && (32'(src) < NREG)) v = r_regs[src];
`ifdef WB_WRITE_BYPASS_EN
        if (w_wrM && (src == r_W_dstM))      v = r_W_valM;
        else if (w_wrE && (src == r_W_dstE)) v = r_W_valE;
`endif
        return v;
    endfunction

    // Decode read ports
    always_comb begin
        d_rvalA = f_read(d_srcA);
        d_rvalB = f_read(d_srcB);
    end

    assign W_stat  = r_W_stat;
    assign W_icode = r_W_icode;
    assign W_valE  = r_W_valE;
    assign W_valM  = r_W_valM;
    assign W_dstE  = r_W_dstE;
    assign W_dstM  = r_W_dstM;
    assign Stat    = r_stat;
    assign halted  = r_halted;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: a reference model predicts the W register,
// Stat/halted and register file contents; expected snapshots are queued when
// stimulus is driven and compared with DUT snapshots taken after each edge.
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic [63:0] M_valE, m_valM;
    logic [3:0]  M_dstE, M_dstM;
    logic        W_stall, W_bubble;
    logic [3:0]  d_srcA, d_srcB;
    logic [63:0] d_rvalA, d_rvalB;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  W_dstE, W_dstM;
    logic [2:0]  Stat;
    logic        halted;

    always #5 clk = ~clk;

    wb_regfile #(.NREG(15)) dut (
        .clk(clk), .rst(rst),
        .M_stat(M_stat), .M_icode(M_icode), .M_valE(M_valE), .m_valM(m_valM),
        .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stall(W_stall), .W_bubble(W_bubble),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .Stat(Stat), .halted(halted)
    );

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } wreg_t;

    typedef struct packed {
        wreg_t      w;
        logic [2:0] st;
        logic       hl;
    } snap_t;

    localparam wreg_t BUB = wreg_t'{3'd1, 4'd1, 64'd0, 64'd0, 4'hF, 4'hF};

    wreg_t       mW;
    logic [63:0] mr [15];
    bit          mhalt = 1'b0;
    logic [2:0]  mstat_l = 3'd1;
    snap_t       exp_q[$];
    snap_t       obs_q[$];
    int          checks = 0;
    int          errors = 0;

    // Model step: predict the edge, queue expectation, clock, capture DUT snapshot
    task automatic step();
        snap_t e, o;
        if (rst) begin
            mW = BUB;
            foreach (mr[i]) mr[i] = '0;
            mhalt   = 1'b0;
            mstat_l = 3'd1;
        end else if (!mhalt) begin
            if (mW.stat == 3'd1) begin
                if (mW.dstE != 4'hF) mr[mW.dstE] = mW.valE;
                if (mW.dstM != 4'hF) mr[mW.dstM] = mW.valM;
            end else if (mW.stat inside {[3'd2:3'd4]}) begin
                mhalt   = 1'b1;
                mstat_l = mW.stat;
            end
            if (!W_stall)
                mW = W_bubble ? BUB : wreg_t'{M_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM};
        end
        e.w  = mW;
        e.st = mhalt ? mstat_l : mW.stat;
        e.hl = mhalt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o.w.stat  = W_stat;
        o.w.icode = W_icode;
        o.w.valE  = W_valE;
        o.w.valM  = W_valM;
        o.w.dstE  = W_dstE;
        o.w.dstM  = W_dstM;
        o.st      = Stat;
        o.hl      = halted;
        obs_q.push_back(o);
    endtask

    function automatic logic [63:0] exp_read(input logic [3:0] s);
        logic [63:0] v;
        v = (s == 4'hF) ? 64'd0 : mr[s];
`ifdef WB_WRITE_BYPASS_EN
        if (!mhalt && mW.stat == 3'd1 && s != 4'hF) begin
            if (mW.dstM == s)      v = mW.valM;
            else if (mW.dstE == s) v = mW.valE;
        end
`endif
        return v;
    endfunction

    task automatic set_m(input logic [2:0] s, input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
        M_stat = s; M_icode = ic; M_valE = ve; m_valM = vm; M_dstE = de; M_dstM = dm;
    endtask

    task automatic test_reset();
        snap_t e, o;
        rst = 1'b1; W_stall = 1'b1; W_bubble = 1'b0;
        set_m(3'd1, 4'h2, 64'h55, 64'h66, 4'd3, 4'd3);
        step();
        rst = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL reset_wreg: got %h expected %h", o, e); end
        end
        checks++;
        if (W_dstE !== 4'hF || Stat !== 3'd1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got dstE=%h Stat=%0d halted=%b expected F 1 0", W_dstE, Stat, halted);
        end
        for (int s = 0; s < 16; s++) begin
            d_srcA = 4'(s); d_srcB = 4'(15 - s); #1;
            checks++;
            if (d_rvalA !== 64'd0 || d_rvalB !== 64'd0) begin
                errors++;
                $display("FAIL reset_read: src %0d got A=%h B=%h expected 0", s, d_rvalA, d_rvalB);
            end
        end
    endtask

    task automatic test_basic_commit();
        snap_t e, o;
        W_stall = 1'b0; W_bubble = 1'b0;
        set_m(3'd1, 4'h3, 64'h1234, 64'h0, 4'd2, 4'hF);
        step();
        checks++;
        if (W_valE !== 64'h1234) begin errors++; $display("FAIL basic_wvalE: got %h expected 1234", W_valE); end
        d_srcA = 4'd2; #1;
        checks++;
        if (d_rvalA !== exp_read(4'd2)) begin
            errors++; $display("FAIL basic_pre_read: got %h expected %h", d_rvalA, exp_read(4'd2));
        end
        W_bubble = 1'b1;
        step();
        checks++;
        if (d_rvalA !== 64'h1234) begin errors++; $display("FAIL basic_read: got %h expected 1234", d_rvalA); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL basic_wreg: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_dual_write();
        snap_t e, o;
        W_stall = 1'b0; W_bubble = 1'b0;
        set_m(3'd1, 4'h5, 64'h10, 64'h20, 4'd4, 4'd4);
        step();
        W_bubble = 1'b1;
        step();
        d_srcB = 4'd4; #1;
        checks++;
        if (d_rvalB !== 64'h20) begin errors++; $display("FAIL dual_write: got %h expected 20", d_rvalB); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL dual_wreg: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_stall_bubble();
        snap_t e, o;
        wreg_t held;
        W_stall = 1'b0; W_bubble = 1'b0;
        set_m(3'd1, 4'h2, 64'hAA, 64'h0, 4'd3, 4'hF);
        step();
        held = wreg_t'{3'd1, 4'h2, 64'hAA, 64'h0, 4'd3, 4'hF};
        W_stall = 1'b1; W_bubble = 1'b1;
        set_m(3'd1, 4'h6, 64'h55, 64'h66, 4'd3, 4'd3);
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM} !== held) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d got valE=%h dstE=%h expected valE=aa dstE=3", c, W_valE, W_dstE);
            end
        end
        d_srcA = 4'd3; #1;
        checks++;
        if (d_rvalA !== 64'hAA) begin errors++; $display("FAIL stall_reg3: got %h expected aa", d_rvalA); end
        W_stall = 1'b0;
        step();
        checks++;
        if ({W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM} !== BUB) begin
            errors++; $display("FAIL bubble_nop: got icode=%h dstE=%h dstM=%h expected 1 F F", W_icode, W_dstE, W_dstM);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL stall_wreg: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_bypass();
        snap_t e, o;
        logic [63:0] want;
        rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
        step();
        rst = 1'b0;
        set_m(3'd1, 4'h2, 64'h99, 64'h0, 4'd7, 4'hF);
        step();
        d_srcB = 4'd7; #1;
`ifdef WB_WRITE_BYPASS_EN
        want = 64'h99;
`else
        want = 64'h0;
`endif
        checks++;
        if (d_rvalB !== want) begin errors++; $display("FAIL bypass_read: got %h expected %h", d_rvalB, want); end
        W_bubble = 1'b1;
        step();
        checks++;
        if (d_rvalB !== 64'h99) begin errors++; $display("FAIL bypass_after: got %h expected 99", d_rvalB); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL bypass_wreg: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_random();
        snap_t e, o;
        for (int c = 0; c < 40; c++) begin
            W_stall  = ($urandom_range(0, 3) == 0);
            W_bubble = ($urandom_range(0, 3) == 0);
            set_m(3'd1, 4'($urandom_range(0, 11)), {$urandom, $urandom}, {$urandom, $urandom},
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            step();
            d_srcA = 4'($urandom_range(0, 15));
            d_srcB = 4'($urandom_range(0, 15));
            #1;
            checks++;
            if (d_rvalA !== exp_read(d_srcA) || d_rvalB !== exp_read(d_srcB)) begin
                errors++;
                $display("FAIL random_read: cycle %0d src %0d/%0d got %h/%h expected %h/%h", c, d_srcA, d_srcB,
                         d_rvalA, d_rvalB, exp_read(d_srcA), exp_read(d_srcB));
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL random_wreg: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_halt();
        snap_t e, o;
        logic [63:0] r5, r6;
        r5 = mr[5]; r6 = mr[6];
        W_stall = 1'b0; W_bubble = 1'b0;
        set_m(3'd3, 4'h5, 64'h0, 64'hFF, 4'hF, 4'd5);
        step();
        set_m(3'd1, 4'h2, 64'h77, 64'h0, 4'd6, 4'hF);
        step();
        checks++;
        if (halted !== 1'b1 || Stat !== 3'd3) begin
            errors++; $display("FAIL halt_enter: got halted=%b Stat=%0d expected 1 3", halted, Stat);
        end
        for (int c = 0; c < 3; c++) begin
            W_stall = c[0]; W_bubble = c[1];
            step();
        end
        d_srcA = 4'd5; d_srcB = 4'd6; #1;
        checks++;
        if (d_rvalA !== r5) begin errors++; $display("FAIL halt_reg5: got %h expected %h", d_rvalA, r5); end
        checks++;
        if (d_rvalB !== r6) begin errors++; $display("FAIL halt_reg6: got %h expected %h", d_rvalB, r6); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (halted !== 1'b0 || Stat !== 3'd1 || d_rvalB !== 64'd0) begin
            errors++; $display("FAIL halt_reset: got halted=%b Stat=%0d reg6=%h expected 0 1 0", halted, Stat, d_rvalB);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL halt_wreg: got %h expected %h", o, e); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0; d_srcA = 4'hF; d_srcB = 4'hF;
        set_m(3'd1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
        #2;
        test_reset();
        test_basic_commit();
        test_dual_write();
        test_stall_bubble();
        test_bypass();
        test_random();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
